// File: rtl/ls_access_ctrl_if.sv
// ls_access_ctrl_if: pipe, DMA and local store signal bundle.
// master = controller side, slave = pipe/DMA/memory environment.
interface ls_access_ctrl_if;
  logic         p_valid;
  logic         p_ready;
  logic         p_store;
  logic [31:0]  p_addr;
  logic [127:0] p_data;
  logic [15:0]  p_bmask;
  logic [6:0]   p_tag;
  logic         p_rsp_valid;
  logic [6:0]   p_rsp_tag;
  logic [127:0] p_rsp_data;
  logic         d_valid;
  logic         d_ready;
  logic         d_store;
  logic [31:0]  d_addr;
  logic [127:0] d_data;
  logic         d_rsp_valid;
  logic [127:0] d_rsp_data;
  logic [31:0]  ls_addr;
  logic         ls_wr_en;
  logic [127:0] ls_data_wr;
  logic [127:0] ls_data_rd;

  modport master (
    input  p_valid, p_store, p_addr, p_data, p_bmask, p_tag,
    output p_ready, p_rsp_valid, p_rsp_tag, p_rsp_data,
    input  d_valid, d_store, d_addr, d_data,
    output d_ready, d_rsp_valid, d_rsp_data,
    output ls_addr, ls_wr_en, ls_data_wr,
    input  ls_data_rd
  );

  modport slave (
    output p_valid, p_store, p_addr, p_data, p_bmask, p_tag,
    input  p_ready, p_rsp_valid, p_rsp_tag, p_rsp_data,
    output d_valid, d_store, d_addr, d_data,
    input  d_ready, d_rsp_valid, d_rsp_data,
    input  ls_addr, ls_wr_en, ls_data_wr,
    output ls_data_rd
  );
endinterface

// File: rtl/ls_access_ctrl.sv
// ls_access_ctrl: SPU local store initiator, pipe/DMA arbitration,
// byte-merged stores, fixed-latency load return.
// Ports: clk, rst (async active-low), bus (ls_access_ctrl_if.master).
module ls_access_ctrl #(
  parameter int LS_BYTES   = 262144,
  parameter int LOAD_LAT   = 6,
  parameter int DMA_STARVE = 8
) (
  input logic              clk,
  input logic              rst,
  ls_access_ctrl_if.master bus
);

  localparam logic [31:0] AMASK = 32'(LS_BYTES - 1);
  localparam int SCW = $clog2(DMA_STARVE + 1);
  localparam int DL  = LOAD_LAT - 1;

  logic [SCW-1:0] r_sc;
  logic           w_force;
  logic           w_p_go;
  logic           w_d_go;
  logic [31:0]    w_p_idx;
  logic [31:0]    w_d_idx;

  assign w_force = (r_sc == SCW'(DMA_STARVE));
  assign bus.p_ready = rst & ~w_force;
  assign bus.d_ready = rst & (w_force | ~bus.p_valid);
  assign w_p_go = bus.p_valid & bus.p_ready;
  assign w_d_go = bus.d_valid & bus.d_ready;
  assign w_p_idx = (bus.p_addr & AMASK) >> 4;
  assign w_d_idx = (bus.d_addr & AMASK) >> 4;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sc <= '0;
    end else if (w_d_go || !bus.d_valid) begin
      r_sc <= '0;
    end else if (w_p_go) begin
      r_sc <= r_sc + 1'b1;
    end
  end

  // access stage
  logic         r_acc_v;
  logic         r_acc_dma;
  logic         r_acc_st;
  logic [31:0]  r_acc_idx;
  logic [6:0]   r_acc_tag;
  logic [15:0]  r_acc_mask;
  logic [127:0] r_acc_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc_v    <= 1'b0;
      r_acc_dma  <= 1'b0;
      r_acc_st   <= 1'b0;
      r_acc_idx  <= '0;
      r_acc_tag  <= '0;
      r_acc_mask <= '0;
      r_acc_data <= '0;
    end else begin
      r_acc_v <= w_p_go | w_d_go;
      if (w_d_go) begin
        r_acc_dma  <= 1'b1;
        r_acc_st   <= bus.d_store;
        r_acc_idx  <= w_d_idx;
        r_acc_tag  <= '0;
        r_acc_mask <= '1;
        r_acc_data <= bus.d_data;
      end else if (w_p_go) begin
        r_acc_dma  <= 1'b0;
        r_acc_st   <= bus.p_store;
        r_acc_idx  <= w_p_idx;
        r_acc_tag  <= bus.p_tag;
        r_acc_mask <= bus.p_bmask;
        r_acc_data <= bus.p_data;
      end
    end
  end

  logic [127:0] w_wdata;

  // Non-write cycles pass read data through so a free-running
  // memory write leaves contents unchanged.
  always_comb begin
    w_wdata = bus.ls_data_rd;
    if (r_acc_v && r_acc_st) begin
      for (int b = 0; b < 16; b++) begin
        if (r_acc_mask[b]) begin
          w_wdata[8*b +: 8] = r_acc_data[8*b +: 8];
        end
      end
    end
  end

  assign bus.ls_addr    = r_acc_idx;
  assign bus.ls_wr_en   = r_acc_v & r_acc_st;
  assign bus.ls_data_wr = w_wdata;

  // read capture at end of access cycle
  logic         r_cap_pv;
  logic         r_cap_dv;
  logic [6:0]   r_cap_tag;
  logic [127:0] r_cap_data;
  logic         r_drsp_v;
  logic [127:0] r_drsp_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cap_pv    <= 1'b0;
      r_cap_dv    <= 1'b0;
      r_cap_tag   <= '0;
      r_cap_data  <= '0;
      r_drsp_v    <= 1'b0;
      r_drsp_data <= '0;
    end else begin
      r_cap_pv   <= r_acc_v & ~r_acc_dma & ~r_acc_st;
      r_cap_dv   <= r_acc_v & r_acc_dma & ~r_acc_st;
      r_cap_tag  <= r_acc_tag;
      r_cap_data <= bus.ls_data_rd;
      r_drsp_v   <= r_cap_dv;
      if (r_cap_dv) begin
        r_drsp_data <= r_cap_data;
      end
    end
  end

  assign bus.d_rsp_valid = r_drsp_v;
  assign bus.d_rsp_data  = r_drsp_data;

  // pipe load delay line
  logic [DL-1:0] r_dl_v;
  logic [6:0]    r_dl_tag  [DL];
  logic [127:0]  r_dl_data [DL];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dl_v <= '0;
      for (int k = 0; k < DL; k++) begin
        r_dl_tag[k]  <= '0;
        r_dl_data[k] <= '0;
      end
    end else begin
      r_dl_v[0]    <= r_cap_pv;
      r_dl_tag[0]  <= r_cap_tag;
      r_dl_data[0] <= r_cap_data;
      for (int k = 1; k < DL; k++) begin
        r_dl_v[k]    <= r_dl_v[k-1];
        r_dl_tag[k]  <= r_dl_tag[k-1];
        r_dl_data[k] <= r_dl_data[k-1];
      end
    end
  end

  assign bus.p_rsp_valid = r_dl_v[DL-1];
  assign bus.p_rsp_tag   = r_dl_tag[DL-1];
  assign bus.p_rsp_data  = r_dl_data[DL-1];

endmodule

// File: tb/tb_ls_access_ctrl.sv
// tb_ls_access_ctrl: directed vector bench for ls_access_ctrl
// with a behavioural local store behind the ls_* port.
module tb_ls_access_ctrl;

  localparam int LAT = 6;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  ls_access_ctrl_if bus ();

  ls_access_ctrl #(
    .LS_BYTES  (32768),
    .LOAD_LAT  (LAT),
    .DMA_STARVE(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [127:0] mem [2048];
  assign bus.ls_data_rd = mem[bus.ls_addr[10:0]];
  always @(posedge clk) begin
    if (bus.ls_wr_en) mem[bus.ls_addr[10:0]] <= bus.ls_data_wr;
  end

  typedef struct {
    logic         st;
    logic [31:0]  addr;
    logic [127:0] data;
    logic [15:0]  mask;
    logic [6:0]   tag;
    logic [31:0]  ex_idx;
    logic [127:0] ex_rd;
  } vec_t;

  vec_t vt [10];

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, want);
    end
  endtask

  // starts and ends at a negedge
  task automatic do_pipe(input vec_t v);
    int n;
    bit got;
    bus.p_valid = 1'b1;
    bus.p_store = v.st;
    bus.p_addr  = v.addr;
    bus.p_data  = v.data;
    bus.p_bmask = v.mask;
    bus.p_tag   = v.tag;
    chk("p_ready", bus.p_ready, 1);
    @(posedge clk); #1;
    bus.p_valid = 1'b0;
    chk("ls_addr", bus.ls_addr, v.ex_idx);
    chk("ls_wr_en", bus.ls_wr_en, v.st);
    if (!v.st) begin
      n = 0;
      got = 0;
      while (!got && n < 20) begin
        @(posedge clk); #1;
        n++;
        if (bus.p_rsp_valid) got = 1;
      end
      chk("load_lat", n, LAT);
      chk("rsp_tag", bus.p_rsp_tag, v.tag);
      chk("rsp_data", bus.p_rsp_data, v.ex_rd);
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "timeout");
  end

  localparam logic [127:0] D1 = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] D2 = 128'hDEADBEEF0123456789ABCDEFCAFEF00D;
  localparam logic [127:0] ONES = {128{1'b1}};
  localparam logic [127:0] MRG = 128'h00FFFFFFFFFFFFFFFFFFFFFFFFFFFF00;
  localparam logic [127:0] PRT = 128'h0000000000000000AAAAAAAA00000006;
  localparam logic [127:0] AAS = {16{8'hAA}};

  initial begin
    int nresp;
    int nv;
    logic [2:0] dsh;
    bit dg;
    bit pg;

    vt[0] = '{1, 32'h40, D1, 16'hFFFF, 0, 4, 0};
    vt[1] = '{0, 32'h4C, 0, 0, 5, 4, D1};
    vt[2] = '{1, 32'h100, ONES, 16'hFFFF, 0, 16, 0};
    vt[3] = '{1, 32'h100, 0, 16'h8001, 0, 16, 0};
    vt[4] = '{0, 32'h10F, 0, 0, 7, 16, MRG};
    vt[5] = '{1, 32'h8010, D2, 16'hFFFF, 0, 1, 0};
    vt[6] = '{0, 32'h10, 0, 0, 9, 1, D2};
    vt[7] = '{1, 32'h60, AAS, 16'h00F0, 0, 6, 0};
    vt[8] = '{0, 32'h6F, 0, 0, 3, 6, PRT};
    vt[9] = '{0, 32'h12345678, 0, 0, 7'h7F, 32'h567, 128'h567};

    for (int i = 0; i < 2048; i++) mem[i] = 128'(i);
    bus.p_valid = 0; bus.p_store = 0; bus.p_addr = 0;
    bus.p_data = 0; bus.p_bmask = 0; bus.p_tag = 0;
    bus.d_valid = 0; bus.d_store = 0; bus.d_addr = 0; bus.d_data = 0;

    #2;
    chk("rst_p_ready", bus.p_ready, 0);
    chk("rst_d_ready", bus.d_ready, 0);
    chk("rst_ls_addr", bus.ls_addr, 0);
    chk("rst_ls_wr_en", bus.ls_wr_en, 0);
    chk("rst_p_rsp_valid", bus.p_rsp_valid, 0);
    chk("rst_p_rsp_tag", bus.p_rsp_tag, 0);
    chk("rst_p_rsp_data", bus.p_rsp_data, 0);
    chk("rst_d_rsp_valid", bus.d_rsp_valid, 0);
    chk("rst_d_rsp_data", bus.d_rsp_data, 0);
    chk("rst_ls_data_wr", bus.ls_data_wr, bus.ls_data_rd);

    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) do_pipe(vt[i]);

    // ten back-to-back loads
    nresp = 0;
    for (int k = 0; k < LAT + 12; k++) begin
      if (k < 10) begin
        bus.p_valid = 1;
        bus.p_store = 0;
        bus.p_addr  = 32'h200 + 32'(k * 16);
        bus.p_tag   = 7'(k + 1);
      end else begin
        bus.p_valid = 0;
      end
      @(posedge clk); #1;
      if (bus.p_rsp_valid) begin
        chk("b2b_tag", bus.p_rsp_tag, 128'(nresp + 1));
        chk("b2b_cycle", k, nresp + LAT);
        chk("b2b_data", bus.p_rsp_data, 128'(32'h20 + nresp));
        nresp++;
      end
      @(negedge clk);
    end
    chk("b2b_count", nresp, 10);

    // starvation: both ports held valid
    dsh = '0;
    for (int c = 0; c < 29; c++) begin
      bus.p_valid = (c <= 26);
      bus.p_store = 0;
      bus.p_addr  = 32'h300;
      bus.p_tag   = 0;
      bus.d_valid = (c <= 26);
      bus.d_store = 0;
      bus.d_addr  = 32'h310;
      #1;
      pg = bus.p_valid & bus.p_ready;
      dg = bus.d_valid & bus.d_ready;
      if (c <= 26) begin
        chk("one_grant", 32'(pg) + 32'(dg), 1);
        chk("dma_grant", dg, (c % 9) == 8);
      end
      @(posedge clk); #1;
      dsh = {dsh[1:0], dg};
      chk("d_rsp_valid", bus.d_rsp_valid, dsh[2]);
      if (bus.d_rsp_valid) chk("d_rsp_data", bus.d_rsp_data, 128'h31);
      @(negedge clk);
    end

    repeat (10) @(negedge clk);

    // reset with three loads in flight
    for (int k = 0; k < 3; k++) begin
      bus.p_valid = 1;
      bus.p_store = 0;
      bus.p_addr  = 32'h400 + 32'(k * 16);
      bus.p_tag   = 7'(20 + k);
      @(negedge clk);
    end
    bus.p_valid = 0;
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("ar_p_ready", bus.p_ready, 0);
    chk("ar_d_ready", bus.d_ready, 0);
    chk("ar_ls_addr", bus.ls_addr, 0);
    chk("ar_ls_wr_en", bus.ls_wr_en, 0);
    chk("ar_p_rsp_valid", bus.p_rsp_valid, 0);
    chk("ar_d_rsp_valid", bus.d_rsp_valid, 0);
    chk("ar_ls_data_wr", bus.ls_data_wr, bus.ls_data_rd);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("post_p_ready", bus.p_ready, 1);
    nv = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (bus.p_rsp_valid) nv++;
    end
    chk("dropped_loads", nv, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
